// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, ALU operation classes, state encoding and per-state control
// decode for the multicycle MIPS controller.
package mips_ctrl_pkg;

    localparam logic [5:0] R_TYPE   = 6'h00;
    localparam logic [5:0] ADDI     = 6'h08;
    localparam logic [5:0] ANDI     = 6'h0c;
    localparam logic [5:0] ORI      = 6'h0d;
    localparam logic [5:0] LUI      = 6'h0f;
    localparam logic [5:0] LW       = 6'h23;
    localparam logic [5:0] SW       = 6'h2b;
    localparam logic [5:0] BEQ      = 6'h04;
    localparam logic [5:0] BNE      = 6'h05;
    localparam logic [5:0] J        = 6'h02;
    localparam logic [5:0] JAL      = 6'h03;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'b011;
    localparam logic [2:0] ALU_SUB   = 3'b110;
    localparam logic [2:0] ALU_OR    = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_LUI   = 3'b101;
    localparam logic [2:0] ALU_ADDI  = 3'b100;
    localparam logic [2:0] ALU_RTYPE = 3'b111;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_WB_R     = 4'd4,
        S_EXEC_I   = 4'd5,
        S_WB_I     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_WB_LW    = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_JAL      = 4'd13,
        S_JR       = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    typedef struct packed {
        logic       memReq;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       pcWrite;
        logic       pcWriteCondEQ;
        logic       pcWriteCondNE;
        logic [1:0] pcSource;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluOp;
        logic       regDst;
        logic       memtoReg;
        logic       regWrite;
        logic       jal;
    } ctrl_t;

    // Moore control word for a state; the fetch-complete strobes are added separately.
    function automatic ctrl_t decodeCtrl(input state_t st, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (st)
            S_FETCH: begin
                c.memReq  = 1'b1;
                c.memRead = 1'b1;
                c.aluSrcB = 2'b01;
                c.aluOp   = ALU_ADD;
            end
            S_DECODE: begin
                c.aluSrcB = 2'b11;
                c.aluOp   = ALU_ADD;
            end
            S_EXEC_R: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = ALU_RTYPE;
            end
            S_WB_R: begin
                c.regDst   = 1'b1;
                c.regWrite = 1'b1;
            end
            S_EXEC_I: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
                case (op)
                    ADDI:    c.aluOp = ALU_ADDI;
                    ANDI:    c.aluOp = ALU_AND;
                    ORI:     c.aluOp = ALU_OR;
                    LUI:     c.aluOp = ALU_LUI;
                    default: c.aluOp = ALU_ADD;
                endcase
            end
            S_WB_I:   c.regWrite = 1'b1;
            S_MEM_ADDR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
                c.aluOp   = ALU_ADD;
            end
            S_MEM_RD: begin
                c.memReq  = 1'b1;
                c.memRead = 1'b1;
                c.iorD    = 1'b1;
            end
            S_WB_LW: begin
                c.memtoReg = 1'b1;
                c.regWrite = 1'b1;
            end
            S_MEM_WR: begin
                c.memReq   = 1'b1;
                c.memWrite = 1'b1;
                c.iorD     = 1'b1;
            end
            S_BRANCH: begin
                c.aluSrcA       = 1'b1;
                c.aluOp         = ALU_SUB;
                c.pcSource      = 2'b01;
                c.pcWriteCondEQ = (op == BEQ);
                c.pcWriteCondNE = (op == BNE);
            end
            S_JUMP: begin
                c.pcWrite  = 1'b1;
                c.pcSource = 2'b10;
            end
            S_JAL: begin
                c.pcWrite  = 1'b1;
                c.pcSource = 2'b10;
                c.jal      = 1'b1;
                c.regWrite = 1'b1;
            end
            S_JR: begin
                c.pcWrite  = 1'b1;
                c.pcSource = 2'b11;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles of a memory access and flags the cycle in which the
// access would exhaust its wait budget without a ready.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic mem_ready,
    output logic expired
);

    logic [CNT_WIDTH-1:0] count_r;

    // A ready always ends the access, so it doubles as the clear for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (!active || mem_ready) begin
            count_r <= '0;
        end else if (count_r != {CNT_WIDTH{1'b1}}) begin
            count_r <= count_r + CNT_WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = active && !mem_ready && (count_r == CNT_WIDTH'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: registered Moore control word per state, plus
// the fetch-complete IR/PC strobes which follow mem_ready in the same cycle.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_WIDTH = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [5:0]             OP,
    input  logic [5:0]             Funct,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   IRWrite,
    output logic                   PCWrite,
    output logic                   PCWriteCondEQ,
    output logic                   PCWriteCondNE,
    output logic [1:0]             PCSource,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic [ALUOP_WIDTH-1:0] ALUOp,
    output logic                   RegDst,
    output logic                   MemtoReg,
    output logic                   RegWrite,
    output logic                   Jal,
    output logic                   illegal_op,
    output logic                   mem_timeout,
    output logic [3:0]             state_o
);

    state_t state_r;
    state_t nextState_s;
    ctrl_t  ctrl_r;
    logic   illegal_r;
    logic   timeout_r;
    logic   inMem_s;
    logic   expired_s;
    logic   fetchDone_s;

    assign inMem_s     = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
    assign fetchDone_s = (state_r == S_FETCH) && mem_ready;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_memWaitTimer (
        .clk      (clk),
        .rst_n    (reset),
        .active   (inMem_s),
        .mem_ready(mem_ready),
        .expired  (expired_s)
    );

    // Next-state selection; a ready in the last budget cycle still completes normally.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            S_RESET: nextState_s = S_FETCH;
            S_FETCH: begin
                if (mem_ready)      nextState_s = S_DECODE;
                else if (expired_s) nextState_s = S_TRAP;
                else                nextState_s = S_FETCH;
            end
            S_DECODE: begin
                case (OP)
                    R_TYPE:               nextState_s = (Funct == FUNCT_JR) ? S_JR : S_EXEC_R;
                    ADDI, ANDI, ORI, LUI: nextState_s = S_EXEC_I;
                    LW, SW:               nextState_s = S_MEM_ADDR;
                    BEQ, BNE:             nextState_s = S_BRANCH;
                    J:                    nextState_s = S_JUMP;
                    JAL:                  nextState_s = S_JAL;
                    default:              nextState_s = S_TRAP;
                endcase
            end
            S_EXEC_R:   nextState_s = S_WB_R;
            S_EXEC_I:   nextState_s = S_WB_I;
            S_MEM_ADDR: nextState_s = (OP == SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready)      nextState_s = S_WB_LW;
                else if (expired_s) nextState_s = S_TRAP;
                else                nextState_s = S_MEM_RD;
            end
            S_MEM_WR: begin
                if (mem_ready)      nextState_s = S_FETCH;
                else if (expired_s) nextState_s = S_TRAP;
                else                nextState_s = S_MEM_WR;
            end
            S_WB_R, S_WB_I, S_WB_LW, S_BRANCH, S_JUMP, S_JAL, S_JR: nextState_s = S_FETCH;
            S_TRAP:  nextState_s = S_TRAP;
            default: nextState_s = S_TRAP;
        endcase
    end

    // State, registered control word for the upcoming state, and sticky trap causes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= S_RESET;
            ctrl_r    <= '0;
            illegal_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= nextState_s;
            ctrl_r    <= decodeCtrl(nextState_s, OP);
            illegal_r <= illegal_r || ((state_r == S_DECODE) && (nextState_s == S_TRAP));
            timeout_r <= timeout_r || expired_s;
        end
    end

    assign mem_req       = ctrl_r.memReq;
    assign IorD          = ctrl_r.iorD;
    assign MemRead       = ctrl_r.memRead;
    assign MemWrite      = ctrl_r.memWrite;
    assign IRWrite       = fetchDone_s;
    assign PCWrite       = ctrl_r.pcWrite || fetchDone_s;
    assign PCWriteCondEQ = ctrl_r.pcWriteCondEQ;
    assign PCWriteCondNE = ctrl_r.pcWriteCondNE;
    assign PCSource      = ctrl_r.pcSource;
    assign ALUSrcA       = ctrl_r.aluSrcA;
    assign ALUSrcB       = ctrl_r.aluSrcB;
    assign ALUOp         = ALUOP_WIDTH'(ctrl_r.aluOp);
    assign RegDst        = ctrl_r.regDst;
    assign MemtoReg      = ctrl_r.memtoReg;
    assign RegWrite      = ctrl_r.regWrite;
    assign Jal           = ctrl_r.jal;
    assign illegal_op    = illegal_r;
    assign mem_timeout   = timeout_r;
    assign state_o       = state_r;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench: instruction-level reference model producing the expected
// state walk and control outputs, driven by directed and randomized programs.
module tb_mips_multicycle_control;
    import mips_ctrl_pkg::*;

    localparam int MEM_TO = 4;

    logic       clk;
    logic       reset;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite;
    logic       PCWriteCondEQ, PCWriteCondNE, ALUSrcA, RegDst, MemtoReg, RegWrite, Jal;
    logic       illegal_op, mem_timeout;
    logic [1:0] PCSource, ALUSrcB;
    logic [2:0] ALUOp;
    logic [3:0] state_o;

    int     nTests = 0;
    int     nFail  = 0;
    logic   expIllegal = 1'b0;
    logic   expTimeout = 1'b0;
    string  curTag = "init";
    state_t bodyQ[$];

    mips_multicycle_control #(.ALUOP_WIDTH(3), .MEM_TIMEOUT(MEM_TO), .CNT_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCondEQ(PCWriteCondEQ),
        .PCWriteCondNE(PCWriteCondNE), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .Jal(Jal), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state_o(state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [21:0] obsVec = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite,
                          PCWriteCondEQ, PCWriteCondNE, PCSource, ALUSrcA, ALUSrcB,
                          ALUOp, RegDst, MemtoReg, RegWrite, Jal, illegal_op, mem_timeout};

    // Output table taken from the per-state rules, expressed as named fields.
    function automatic logic [21:0] expOutputs(input state_t st, input logic [5:0] op, input logic rdy);
        logic memReq, iorD, memRd, memWr, irW, pcW, cEq, cNe, srcA, regDst, m2r, regW, jal;
        logic [1:0] pcSrc, srcB;
        logic [2:0] aluOp;
        {memReq, iorD, memRd, memWr, irW, pcW, cEq, cNe, srcA, regDst, m2r, regW, jal} = '0;
        pcSrc = 2'b00; srcB = 2'b00; aluOp = 3'b000;
        case (st)
            S_FETCH:    begin memReq = 1; memRd = 1; srcB = 2'b01; aluOp = 3'b011; irW = rdy; pcW = rdy; end
            S_DECODE:   begin srcB = 2'b11; aluOp = 3'b011; end
            S_EXEC_R:   begin srcA = 1; aluOp = 3'b111; end
            S_WB_R:     begin regDst = 1; regW = 1; end
            S_EXEC_I:   begin
                srcA = 1; srcB = 2'b10;
                aluOp = (op == 6'h08) ? 3'b100 : (op == 6'h0c) ? 3'b010 : (op == 6'h0d) ? 3'b001 : 3'b101;
            end
            S_WB_I:     regW = 1;
            S_MEM_ADDR: begin srcA = 1; srcB = 2'b10; aluOp = 3'b011; end
            S_MEM_RD:   begin memReq = 1; memRd = 1; iorD = 1; end
            S_WB_LW:    begin m2r = 1; regW = 1; end
            S_MEM_WR:   begin memReq = 1; memWr = 1; iorD = 1; end
            S_BRANCH:   begin srcA = 1; aluOp = 3'b110; pcSrc = 2'b01; cEq = (op == 6'h04); cNe = (op == 6'h05); end
            S_JUMP:     begin pcW = 1; pcSrc = 2'b10; end
            S_JAL:      begin pcW = 1; pcSrc = 2'b10; jal = 1; regW = 1; end
            S_JR:       begin pcW = 1; pcSrc = 2'b11; end
            default:    ;
        endcase
        return {memReq, iorD, memRd, memWr, irW, pcW, cEq, cNe, pcSrc, srcA, srcB,
                aluOp, regDst, m2r, regW, jal, expIllegal, expTimeout};
    endfunction

    task automatic check(input state_t st, input logic rdy);
        logic [21:0] e;
        e = expOutputs(st, OP, rdy);
        nTests++;
        assert (state_o === st) else begin
            nFail++;
            $error("FAIL %s state: observed %0d expected %0d", curTag, state_o, st);
        end
        nTests++;
        assert (obsVec === e) else begin
            nFail++;
            $error("FAIL %s outputs in %0d: observed %b expected %b", curTag, st, obsVec, e);
        end
    endtask

    // Called at a falling edge: drive, check mid-cycle, advance to the next falling edge.
    task automatic step(input state_t st, input logic rdy);
        mem_ready = rdy;
        #1;
        check(st, rdy);
        @(negedge clk);
    endtask

    // Instruction-level model: states visited after DECODE.
    task automatic buildBody(input logic [5:0] op, input logic [5:0] fn);
        bodyQ.delete();
        case (op)
            6'h00:                      if (fn == 6'h08) bodyQ.push_back(S_JR);
                                        else begin bodyQ.push_back(S_EXEC_R); bodyQ.push_back(S_WB_R); end
            6'h08, 6'h0c, 6'h0d, 6'h0f: begin bodyQ.push_back(S_EXEC_I); bodyQ.push_back(S_WB_I); end
            6'h23:                      begin bodyQ.push_back(S_MEM_ADDR); bodyQ.push_back(S_MEM_RD); bodyQ.push_back(S_WB_LW); end
            6'h2b:                      begin bodyQ.push_back(S_MEM_ADDR); bodyQ.push_back(S_MEM_WR); end
            6'h04, 6'h05:               bodyQ.push_back(S_BRANCH);
            6'h02:                      bodyQ.push_back(S_JUMP);
            6'h03:                      bodyQ.push_back(S_JAL);
            default:                    bodyQ.push_back(S_TRAP);
        endcase
    endtask

    // A memory phase: 'waits' stalled cycles then ready, or trap after MEM_TO stalls.
    task automatic memPhase(input state_t st, input int waits, output bit trapped);
        trapped = 1'b0;
        for (int k = 1; k <= MEM_TO; k++) begin
            step(st, (k > waits));
            if (k > waits) return;
            if (k == MEM_TO) begin
                expTimeout = 1'b1;
                trapped    = 1'b1;
            end
        end
    endtask

    task automatic runInstr(input logic [5:0] op, input logic [5:0] fn,
                            input int fWaits, input int mWaits, output bit trapped);
        OP = op;
        Funct = fn;
        memPhase(S_FETCH, fWaits, trapped);
        if (trapped) return;
        step(S_DECODE, 1'($urandom % 2));
        buildBody(op, fn);
        if (bodyQ[0] == S_TRAP) begin
            expIllegal = 1'b1;
            trapped    = 1'b1;
            return;
        end
        foreach (bodyQ[i]) begin
            if (bodyQ[i] == S_MEM_RD || bodyQ[i] == S_MEM_WR) begin
                memPhase(bodyQ[i], mWaits, trapped);
                if (trapped) return;
            end else begin
                step(bodyQ[i], 1'($urandom % 2));
            end
        end
    endtask

    task automatic holdTrap(input int n);
        for (int i = 0; i < n; i++) begin
            OP = 6'($urandom);
            step(S_TRAP, 1'($urandom % 2));
        end
    endtask

    // Asynchronous assertion is checked before any clock edge can occur.
    task automatic applyReset();
        reset = 1'b0;
        #1;
        expIllegal = 1'b0;
        expTimeout = 1'b0;
        check(S_RESET, mem_ready);
        @(negedge clk);
        step(S_RESET, 1'b1);
        reset = 1'b1;
        step(S_RESET, 1'b1);
    endtask

    logic [5:0] legalOps [12] = '{6'h00, 6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0f,
                                  6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};

    initial begin
        bit tr;
        logic [5:0] op, fn;
        reset = 1'b0; OP = 6'h00; Funct = 6'h20; mem_ready = 1'b0;
        @(negedge clk);
        curTag = "reset";
        step(S_RESET, 1'b1);
        step(S_RESET, 1'b0);
        reset = 1'b1;
        step(S_RESET, 1'b1);

        curTag = "add";   runInstr(6'h00, 6'h20, 0, 0, tr);
        curTag = "lw";    runInstr(6'h23, 6'h00, 0, 3, tr);
        curTag = "bne";   runInstr(6'h05, 6'h00, 1, 0, tr);
        curTag = "beq";   runInstr(6'h04, 6'h00, 0, 0, tr);
        curTag = "jal";   runInstr(6'h03, 6'h00, 0, 0, tr);
        curTag = "jr";    runInstr(6'h00, 6'h08, 0, 0, tr);
        curTag = "sw";    runInstr(6'h2b, 6'h00, 2, 2, tr);
        curTag = "addi";  runInstr(6'h08, 6'h00, 0, 0, tr);
        curTag = "andi";  runInstr(6'h0c, 6'h00, 0, 0, tr);
        curTag = "ori";   runInstr(6'h0d, 6'h00, 0, 0, tr);
        curTag = "lui";   runInstr(6'h0f, 6'h00, 0, 0, tr);
        curTag = "j";     runInstr(6'h02, 6'h00, 0, 0, tr);
        curTag = "fetch_ready_last"; runInstr(6'h00, 6'h22, MEM_TO - 1, 0, tr);

        curTag = "random";
        for (int i = 0; i < 40; i++) begin
            op = legalOps[$urandom_range(0, 11)];
            fn = 6'($urandom);
            if (op == 6'h00 && ($urandom % 4) == 0) fn = 6'h08;
            else if (fn == 6'h08) fn = 6'h20;
            runInstr(op, fn, $urandom_range(0, MEM_TO - 1), $urandom_range(0, MEM_TO - 1), tr);
        end

        curTag = "fetch_timeout";
        runInstr(6'h00, 6'h20, 10, 0, tr);
        holdTrap(20);
        curTag = "reset_after_timeout";
        applyReset();

        curTag = "illegal";
        runInstr(6'h3f, 6'h00, 0, 0, tr);
        holdTrap(20);
        curTag = "reset_after_illegal";
        applyReset();

        curTag = "lw_timeout";
        runInstr(6'h23, 6'h00, 0, 10, tr);
        holdTrap(3);
        applyReset();

        curTag = "reset_mid_sw";
        OP = 6'h2b; Funct = 6'h00;
        step(S_FETCH, 1'b1);
        step(S_DECODE, 1'b0);
        step(S_MEM_ADDR, 1'b1);
        mem_ready = 1'b0;
        #1;
        check(S_MEM_WR, 1'b0);
        #1;
        applyReset();
        curTag = "restart";
        runInstr(6'h00, 6'h20, 0, 0, tr);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle successor to the single-cycle MIPS control decoder.
- A state machine sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK for the same instruction set plus ANDI and a correct JR decode via Funct.
- Memory accesses use a ready handshake with a parametrised timeout.
- Illegal opcodes and memory timeouts trap to a sticky error state. Sits between the instruction register and the multicycle datapath muxes.

Parameters:
- ALUOP_WIDTH, 3, width of ALUOp output.
- MEM_TIMEOUT, 15, max cycles waiting for mem_ready in any memory state before trapping (1..255).
- CNT_WIDTH, 8, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- OP  in  6  opcode field of the instruction register.
- Funct  in  6  funct field; 6'h08 with OP=0 is JR.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- IorD  out  1  0 = PC address, 1 = ALUOut address.
- MemRead  out  1  read strobe.
- MemWrite  out  1  write strobe.
- IRWrite  out  1  load instruction register.
- PCWrite  out  1  unconditional PC load.
- PCWriteCondEQ  out  1  PC load if Zero.
- PCWriteCondNE  out  1  PC load if not Zero.
- PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 register rs.
- ALUSrcA  out  1  0 = PC, 1 = rs.
- ALUSrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 shifted sign-ext imm.
- ALUOp  out  ALUOP_WIDTH  ALU operation class.
- RegDst  out  1  0 = rt, 1 = rd.
- MemtoReg  out  1  write-back from MDR.
- RegWrite  out  1  register-file write.
- Jal  out  1  write PC into $31.
- illegal_op  out  1  sticky: undefined opcode/funct trapped.
- mem_timeout  out  1  sticky: memory did not answer.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset (reset=0, asynchronous): state = S_RESET, wait counter = 0, both sticky flags = 0.
- In S_RESET every output is 0. S_RESET always moves to S_FETCH on the next edge.
- Default: every output is 0 unless listed for the current state.
- S_FETCH: mem_req=1, MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD, PCSource=00.
  - When mem_ready=1: IRWrite=1 and PCWrite=1 in that same cycle (Mealy), then go to S_DECODE.
  - Otherwise stay.
- S_DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=ADD (branch target). Next state by OP:
  - 0 with Funct=08 -> S_JR; other OP=0 -> S_EXEC_R.
  - 08/0c/0d/0f -> S_EXEC_I.
  - 23/2b -> S_MEM_ADDR.
  - 04/05 -> S_BRANCH.
  - 02 -> S_JUMP; 03 -> S_JAL.
  - Anything else -> S_TRAP with illegal_op set.
- S_EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=RTYPE -> S_WB_R.
- S_WB_R: RegDst=1, RegWrite=1 -> S_FETCH.
- S_EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp by OP: ADDI, ANDI, ORI or LUI -> S_WB_I.
- S_WB_I: RegDst=0, RegWrite=1 -> S_FETCH.
- S_MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD -> S_MEM_RD (OP=23) or S_MEM_WR (OP=2b).
- S_MEM_RD: mem_req=1, MemRead=1, IorD=1; leaves on mem_ready -> S_WB_LW.
- S_WB_LW: MemtoReg=1, RegWrite=1 -> S_FETCH.
- S_MEM_WR: mem_req=1, MemWrite=1, IorD=1; leaves on mem_ready -> S_FETCH.
- S_BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, PCSource=01.
  - PCWriteCondEQ=1 for OP=04; PCWriteCondNE=1 for OP=05.
  - -> S_FETCH.
- S_JUMP: PCWrite=1, PCSource=10 -> S_FETCH.
- S_JAL: PCWrite=1, PCSource=10, Jal=1, RegWrite=1 -> S_FETCH.
- S_JR: PCWrite=1, PCSource=11 -> S_FETCH.
- Wait counter:
  - Cleared on entry to any memory state (S_FETCH, S_MEM_RD, S_MEM_WR).
  - Increments each cycle mem_ready=0, saturating.
  - If it reaches MEM_TIMEOUT with mem_ready still 0: go to S_TRAP, set mem_timeout, deassert mem_req.
  - mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT wins (normal completion).
- S_TRAP: all outputs 0 except the sticky flags; exits only on reset.
- mem_ready outside memory states is ignored.
- Reset mid-access immediately drops mem_req and all strobes.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode localparams (R_TYPE, ADDI, ANDI, ORI, LUI, LW, SW, BEQ, BNE, J, JAL) and FUNCT_JR.
  - ALUOp codes: ADD=011, SUB=110, OR=001, AND=010, LUI=101, ADDI=100, RTYPE=111.
  - the state enumeration.
- Natural sub-module: mem_wait_timer (counter plus timeout compare), instantiated once.

Test Plan:
- Release reset, mem_ready=1 constantly, OP=0 Funct=20 -> states RESET, FETCH, DECODE, EXEC_R, WB_R; IRWrite=1 once in FETCH; RegWrite=1 with RegDst=1 in WB_R; 4 cycles per instruction.
- LW (OP=23), mem_ready low 3 cycles in MEM_RD then high -> MemRead and IorD held 4 cycles, then WB_LW with MemtoReg=1 and RegWrite=1; 5 + 3 cycles total.
- BNE (OP=05) -> BRANCH with PCWriteCondNE=1, PCWriteCondEQ=0, ALUOp=110, PCSource=01; JAL (OP=03) -> Jal=1, RegWrite=1, PCSource=10.
- OP=0 Funct=08 -> S_JR with PCWrite=1, PCSource=11, RegWrite=0; OP=3f -> S_TRAP, illegal_op=1 held for 20 cycles.
- MEM_TIMEOUT=4, mem_ready never asserted in FETCH -> mem_timeout=1 and mem_req=0 after 4 wait cycles; mem_ready on the 4th cycle instead -> normal DECODE.
- Assert reset during S_MEM_WR with MemWrite=1 -> MemWrite drops with no clock edge; flags clear; restart from S_RESET.
